p_accum: RTL and testbench

- Sequential accumulator directly downstream of the perceptron multiplier.
- Consumes a stream of LEN products, plus that stage's udf/ovf/rounded flags, and sums them into one saturating dot-product result in O_CONF format.
- Result and sticky flags are presented over a valid/ready handshake to the activation stage.
- Supports INT and FXP dtypes via dconf_t configuration.

---
 rtl/p_accum.sv | 151 +++++++++++++++
 tb/tb_p_accum.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/p_accum.sv
// Saturating dot-product accumulator: sums LEN aligned products into one O_CONF
// result, with sticky udf/ovf/rounded flags, handed off over valid/ready.
package p_accum_pkg;
  typedef enum logic [0:0] {INT = 1'b0, FXP = 1'b1} dtype_e;
  typedef struct packed {
    dtype_e      dtype;
    logic        sign;
    int unsigned prec;
    int          frac;
  } dconf_t;
endpackage

module p_accum #(
  parameter p_accum_pkg::dconf_t I_CONF = '{dtype: p_accum_pkg::FXP, sign: 1'b1, prec: 16, frac: 6},
  parameter p_accum_pkg::dconf_t O_CONF = '{dtype: p_accum_pkg::FXP, sign: 1'b1, prec: 20, frac: 6},
  parameter int LEN = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     clear_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [I_CONF.prec-1:0]   in_i,
  input  logic                     in_udf_i,
  input  logic                     in_ovf_i,
  input  logic                     in_rounded_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [O_CONF.prec-1:0]   out_o,
  output logic                     udf_o,
  output logic                     ovf_o,
  output logic                     rounded_o
);
  localparam int IW  = int'(I_CONF.prec);
  localparam int OW  = int'(O_CONF.prec);
  localparam int AW  = OW + 1;
  localparam int SW  = AW + 1;
  localparam int D   = O_CONF.frac - I_CONF.frac;
  localparam int SHL = (D >= 0) ? D : 0;
  localparam int SHR = (D < 0) ? -D : 0;
  localparam int WW  = IW + AW + SHL + SHR + 2;
  localparam int CW  = (LEN > 1) ? $clog2(LEN) : 1;

  localparam longint MAXL = O_CONF.sign ? (64'sd1 <<< (OW - 1)) - 64'sd1 : (64'sd1 <<< OW) - 64'sd1;
  localparam longint MINL = O_CONF.sign ? -(64'sd1 <<< (OW - 1)) : 64'sd0;
  localparam logic signed [SW-1:0] MAXV = MAXL[SW-1:0];
  localparam logic signed [SW-1:0] MINV = MINL[SW-1:0];

  localparam logic ACC = 1'b0;
  localparam logic OUT = 1'b1;

  // Extend to a wide working width, shift into the output fraction, keep AW bits.
  function automatic logic signed [AW-1:0] align_f(input logic [IW-1:0] v, output logic rnd);
    logic signed [WW-1:0] w;
    w   = signed'({{(WW-IW){I_CONF.sign & v[IW-1]}}, v});
    rnd = 1'b0;
    for (int i = 0; i < IW; i++) begin
      if (i < SHR) rnd = rnd | v[i];
    end
    w = (w <<< SHL) >>> SHR;
    return w[AW-1:0];
  endfunction

  function automatic logic [OW-1:0] sat_f(input logic signed [SW-1:0] s, output logic hi,
                                          output logic lo);
    logic [OW-1:0] r;
    hi = (s > MAXV);
    lo = (s < MINV);
    if (hi)      r = MAXV[OW-1:0];
    else if (lo) r = MINV[OW-1:0];
    else         r = s[OW-1:0];
    return r;
  endfunction

  logic                 state_q, state_d;
  logic [OW-1:0]        acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 udf_q, udf_d, ovf_q, ovf_d, rnd_q, rnd_d;
  logic signed [AW-1:0] al;
  logic                 al_rnd;
  logic signed [SW-1:0] acc_x, al_x, sum;
  logic [OW-1:0]        sat_v;
  logic                 s_hi, s_lo;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    udf_d   = udf_q;
    ovf_d   = ovf_q;
    rnd_d   = rnd_q;
    al      = align_f(in_i, al_rnd);
    acc_x   = signed'({{(SW-OW){O_CONF.sign & acc_q[OW-1]}}, acc_q});
    al_x    = signed'({{(SW-AW){al[AW-1]}}, al});
    sum     = acc_x + al_x;
    sat_v   = sat_f(sum, s_hi, s_lo);

    // Clear wins over any transfer in the same cycle.
    if (clear_i) begin
      state_d = ACC;
      acc_d   = '0;
      cnt_d   = '0;
      udf_d   = 1'b0;
      ovf_d   = 1'b0;
      rnd_d   = 1'b0;
    end else if (state_q == ACC && in_valid_i) begin
      acc_d = sat_v;
      udf_d = udf_q | in_udf_i | s_lo;
      ovf_d = ovf_q | in_ovf_i | s_hi;
      rnd_d = rnd_q | in_rounded_i | al_rnd;
      if (cnt_q == CW'(LEN - 1)) begin
        cnt_d   = '0;
        state_d = OUT;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (state_q == OUT && out_ready_i) begin
      state_d = ACC;
      acc_d   = '0;
      cnt_d   = '0;
      udf_d   = 1'b0;
      ovf_d   = 1'b0;
      rnd_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      udf_q   <= 1'b0;
      ovf_q   <= 1'b0;
      rnd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      udf_q   <= udf_d;
      ovf_q   <= ovf_d;
      rnd_q   <= rnd_d;
    end
  end

  assign in_ready_o  = (state_q == ACC);
  assign out_valid_o = (state_q == OUT);
  assign out_o       = acc_q;
  assign udf_o       = udf_q;
  assign ovf_o       = ovf_q;
  assign rounded_o   = rnd_q;
endmodule

// File: tb/tb_p_accum.sv
// Bench for p_accum: three output formats driven in lockstep from one stimulus,
// checked every cycle against an integer reference plus directed literal results.
module tb_p_accum;
  import p_accum_pkg::*;

  localparam dconf_t IC = '{dtype: FXP, sign: 1'b1, prec: 16, frac: 6};
  localparam dconf_t OA = '{dtype: FXP, sign: 1'b1, prec: 20, frac: 6};
  localparam dconf_t OB = '{dtype: FXP, sign: 1'b1, prec: 16, frac: 4};
  localparam dconf_t OC = '{dtype: FXP, sign: 1'b1, prec: 16, frac: 6};
  localparam int LEN = 4;

  logic clk = 1'b0, reset = 1'b1, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_udf = 1'b0, in_ovf = 1'b0, in_rnd = 1'b0;
  logic [15:0] din = '0;
  logic a_ir, a_ov, a_u, a_o, a_r;
  logic b_ir, b_ov, b_u, b_o, b_r;
  logic c_ir, c_ov, c_u, c_o, c_r;
  logic [19:0] a_out;
  logic [15:0] b_out, c_out;

  always #5 clk = ~clk;

  p_accum #(.I_CONF(IC), .O_CONF(OA), .LEN(LEN)) dut_a (
    .clk_i(clk), .reset_i(reset), .clear_i(clear), .in_valid_i(in_valid), .in_ready_o(a_ir),
    .in_i(din), .in_udf_i(in_udf), .in_ovf_i(in_ovf), .in_rounded_i(in_rnd),
    .out_valid_o(a_ov), .out_ready_i(out_ready), .out_o(a_out), .udf_o(a_u), .ovf_o(a_o),
    .rounded_o(a_r));
  p_accum #(.I_CONF(IC), .O_CONF(OB), .LEN(LEN)) dut_b (
    .clk_i(clk), .reset_i(reset), .clear_i(clear), .in_valid_i(in_valid), .in_ready_o(b_ir),
    .in_i(din), .in_udf_i(in_udf), .in_ovf_i(in_ovf), .in_rounded_i(in_rnd),
    .out_valid_o(b_ov), .out_ready_i(out_ready), .out_o(b_out), .udf_o(b_u), .ovf_o(b_o),
    .rounded_o(b_r));
  p_accum #(.I_CONF(IC), .O_CONF(OC), .LEN(LEN)) dut_c (
    .clk_i(clk), .reset_i(reset), .clear_i(clear), .in_valid_i(in_valid), .in_ready_o(c_ir),
    .in_i(din), .in_udf_i(in_udf), .in_ovf_i(in_ovf), .in_rounded_i(in_rnd),
    .out_valid_o(c_ov), .out_ready_i(out_ready), .out_o(c_out), .udf_o(c_u), .ovf_o(c_o),
    .rounded_o(c_r));

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Reference: real-valued fixed-point sum with clamping, one per output format.
  int     ofr[3] = '{6, 4, 6};
  int     opr[3] = '{20, 16, 16};
  longint m_acc[3];
  bit     m_u[3], m_o[3], m_r[3];
  int     m_n = 0;
  bit     m_hold = 0;

  task automatic m_zero();
    for (int k = 0; k < 3; k++) begin
      m_acc[k] = 0; m_u[k] = 0; m_o[k] = 0; m_r[k] = 0;
    end
    m_n = 0;
    m_hold = 0;
  endtask

  task automatic m_add(input int k, input logic [15:0] v, input bit iu, input bit io, input bit ir);
    longint x, q, s, mx, mn;
    int d;
    x = longint'($signed(v));
    d = ofr[k] - IC.frac;
    if (d >= 0) x = x * (longint'(1) <<< d);
    else begin
      q = x >>> (-d);
      if ((q <<< (-d)) != x) m_r[k] = 1;
      x = q;
    end
    mx = (longint'(1) <<< (opr[k] - 1)) - 1;
    mn = -(longint'(1) <<< (opr[k] - 1));
    s = m_acc[k] + x;
    if (s > mx) begin s = mx; m_o[k] = 1; end
    if (s < mn) begin s = mn; m_u[k] = 1; end
    m_acc[k] = s;
    m_u[k] = m_u[k] | iu;
    m_o[k] = m_o[k] | io;
    m_r[k] = m_r[k] | ir;
  endtask

  initial begin
    m_zero();
    forever begin
      @(posedge clk);
      if (reset || clear) m_zero();
      else if (!m_hold && in_valid) begin
        for (int k = 0; k < 3; k++) m_add(k, din, in_udf, in_ovf, in_rnd);
        m_n++;
        if (m_n == LEN) begin m_hold = 1; m_n = 0; end
      end else if (m_hold && out_ready) m_zero();
    end
  end

  task automatic snap(input int k, output bit ir, output bit ov, output longint o,
                      output bit u, output bit ovf, output bit r);
    case (k)
      0: begin ir = a_ir; ov = a_ov; o = longint'($signed(a_out)); u = a_u; ovf = a_o; r = a_r; end
      1: begin ir = b_ir; ov = b_ov; o = longint'($signed(b_out)); u = b_u; ovf = b_o; r = b_r; end
      default: begin ir = c_ir; ov = c_ov; o = longint'($signed(c_out)); u = c_u; ovf = c_o; r = c_r; end
    endcase
  endtask

  initial begin
    bit ir, ov, u, ovf, r;
    longint o;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < 3; k++) begin
          snap(k, ir, ov, o, u, ovf, r);
          chk($sformatf("in_ready[%0d]", k), ir, !m_hold);
          chk($sformatf("out_valid[%0d]", k), ov, m_hold);
          if (m_hold) begin
            chk($sformatf("out[%0d]", k), o, m_acc[k]);
            chk($sformatf("udf[%0d]", k), u, m_u[k]);
            chk($sformatf("ovf[%0d]", k), ovf, m_o[k]);
            chk($sformatf("rounded[%0d]", k), r, m_r[k]);
          end
        end
      end
    end
  end

  task automatic send(input logic [15:0] v, input bit u = 0, input bit o = 0, input bit r = 0);
    int w;
    @(negedge clk);
    din = v; in_udf = u; in_ovf = o; in_rnd = r; in_valid = 1'b1;
    w = 0;
    while (!a_ir && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) chk("send_timeout", 1, 0);
    @(posedge clk);
  endtask

  task automatic send4(input logic [15:0] v);
    repeat (LEN) send(v);
  endtask

  task automatic expect_res(input string nm, input int k, input longint eo, input bit eu,
                            input bit eov, input bit er);
    bit ir, ov, u, ovf, r;
    longint o;
    int w;
    @(negedge clk);
    in_valid = 1'b0; in_udf = 1'b0; in_ovf = 1'b0; in_rnd = 1'b0;
    w = 0;
    while (!a_ov && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({nm, "_latency"}, w, 0);
    snap(k, ir, ov, o, u, ovf, r);
    chk({nm, "_out"}, o, eo);
    chk({nm, "_udf"}, u, eu);
    chk({nm, "_ovf"}, ovf, eov);
    chk({nm, "_rounded"}, r, er);
  endtask

  initial begin
    logic [19:0] held;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_in_ready", a_ir, 1);
    chk("rst_out_valid", a_ov, 0);
    chk("rst_out", a_out, 0);
    chk("rst_flags", {a_u, a_o, a_r}, 0);
    chk_en = 1;

    send(16'd224); send(16'd128); send(16'hFFB0); send(16'd32);
    expect_res("basic", 0, 304, 0, 0, 0);

    send4(16'h4000);
    expect_res("sat_hi", 2, 32767, 0, 1, 0);
    send4(16'hC000);
    expect_res("sat_lo", 2, -32768, 1, 0, 0);

    @(negedge clk);
    out_ready = 1'b0;
    send4(16'd100);
    @(negedge clk);
    din = 16'd7; in_valid = 1'b1;
    held = a_out;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", a_ir, 0);
      chk("bp_out_hold", a_out, held);
      chk("bp_out_val", a_out, 400);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_handover_ready", a_ir, 1);
    @(posedge clk);
    send(16'd7); send(16'd7); send(16'd7);
    expect_res("bp_next", 0, 28, 0, 0, 0);

    send(16'd100); send(16'd200);
    @(negedge clk);
    in_valid = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_out_valid", a_ov, 0);
    send4(16'd10);
    expect_res("clear", 0, 40, 0, 0, 0);

    send(16'd3); send(16'd0); send(16'd0); send(16'd0);
    expect_res("align_rnd", 1, 0, 0, 0, 1);
    send(16'd64, 0, 1, 0); send(16'd64); send(16'd64); send(16'd64);
    expect_res("ovf_pass", 0, 256, 0, 1, 0);
    send4(16'd64);
    expect_res("ovf_cleared", 0, 256, 0, 0, 0);

    send(16'd50); send(16'd50); send(16'd50);
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_valid", a_ov, 0);
    chk("mid_rst_out", a_out, 0);
    send4(16'd5);
    expect_res("mid_rst_sum", 0, 20, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      in_valid = ($urandom % 4) != 0;
      case ($urandom % 6)
        0: din = 16'h7FFF;
        1: din = 16'h8000;
        2: din = 16'(($urandom % 16) - 8);
        default: din = 16'($urandom);
      endcase
      in_udf = ($urandom % 8) == 0;
      in_ovf = ($urandom % 8) == 0;
      in_rnd = ($urandom % 8) == 0;
      out_ready = ($urandom % 3) != 0;
      clear = ($urandom % 50) == 0;
      reset = ($urandom % 150) == 0;
    end
    @(negedge clk);
    in_valid = 1'b0; clear = 1'b0; reset = 1'b0; out_ready = 1'b1;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
